lsu_seq: RTL and testbench

Load/store sequencer between the execute/memory pipeline stage and a data memory with a ready/valid handshake. It accepts one memory operation at a time and latches its operands. It drives a word-aligned request with byte-lane mask and lane-replicated store data, and waits for the memory. It returns load data already byte/halfword-selected and sign/zero-extended per funct3. It stalls the pipeline for the whole access and flags misaligned operations and memory timeouts without touching memory.

---
 rtl/lsu_seq.sv | 198 +++++++++++++++++++
 tb/tb_lsu_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_seq.sv
// rtl/lsu_seq.sv - load/store sequencer between the memory stage and a ready/valid data memory
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_valid, i_is_load, i_is_store      pipeline presents a memory op
//   i_funct3, i_addr, i_wdata           op width/signedness, byte address, store data
//   o_stall, o_done                     pipeline hold, one-cycle completion pulse
//   o_rdata, o_misaligned, o_err        extended load data and completion status
//   o_dmem_req/wen/addr/mask/wdata      word-aligned memory request
//   i_dmem_ready, i_dmem_rvalid/rdata   memory accept and read response
module lsu_seq #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_err,
  output logic        o_dmem_req,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // One extra count of headroom: ready on the last allowed REQ cycle still
  // advances the counter into WAIT.
  localparam int              CW   = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0]   LAST = CW'(WAIT_LIMIT - 1);

  logic [1:0]    state;
  logic          op_load;
  logic [2:0]    op_funct3;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic          misaligned_q;
  logic          err_q;

  // Access width; anything not explicitly listed for the op type is a word.
  function automatic logic [1:0] size_of(input logic [2:0] f3, input logic load);
    if (f3 == 3'b000 || (load && f3 == 3'b100)) return SZ_B;
    if (f3 == 3'b001 || (load && f3 == 3'b101)) return SZ_H;
    return SZ_W;
  endfunction

  logic [1:0] in_size;
  logic       in_aligned;
  logic       accept;

  assign in_size = size_of(i_funct3, i_is_load);

  always_comb begin
    in_aligned = 1'b1;
    case (in_size)
      SZ_H:    in_aligned = ~i_addr[0];
      SZ_W:    in_aligned = (i_addr[1:0] == 2'b00);
      default: in_aligned = 1'b1;
    endcase
  end

  // Reset gates accept so that o_stall is low while reset is held.
  assign accept = i_rst_n && (state == S_IDLE) && i_valid && (i_is_load || i_is_store);

  logic [1:0]  op_size;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [31:0] wdata_rep;
  logic [31:0] lane_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign op_size = size_of(op_funct3, op_load);
  assign off     = op_addr[1:0];

  always_comb begin
    mask      = 4'b1111;
    wdata_rep = op_wdata;
    case (op_size)
      SZ_B: begin
        mask      = 4'b0001 << off;
        wdata_rep = {4{op_wdata[7:0]}};
      end
      SZ_H: begin
        mask      = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{op_wdata[15:0]}};
      end
      default: begin
        mask      = 4'b1111;
        wdata_rep = op_wdata;
      end
    endcase
  end

  assign lane_shift = i_dmem_rdata >> {off, 3'b000};
  assign byte_sel   = lane_shift[7:0];
  assign half_sel   = off[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

  // funct3[2] marks the unsigned byte/halfword loads.
  always_comb begin
    load_ext = i_dmem_rdata;
    case (op_size)
      SZ_B:    load_ext = op_funct3[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    load_ext = op_funct3[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      op_load      <= 1'b0;
      op_funct3    <= 3'd0;
      op_addr      <= 32'd0;
      op_wdata     <= 32'd0;
      cnt          <= '0;
      rdata_q      <= 32'd0;
      misaligned_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_load      <= i_is_load;
            op_funct3    <= i_funct3;
            op_addr      <= i_addr;
            op_wdata     <= i_wdata;
            cnt          <= '0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            misaligned_q <= ~in_aligned;
            state        <= in_aligned ? S_REQ : S_DONE;
          end
        end
        S_REQ: begin
          // A handshake on the limit cycle wins over the timeout.
          if (i_dmem_ready) begin
            state <= op_load ? S_WAIT : S_DONE;
            cnt   <= cnt + 1'b1;
          end else if (cnt >= LAST) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (i_dmem_rvalid) begin
            rdata_q <= load_ext;
            state   <= S_DONE;
          end else if (cnt >= LAST) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_stall      = (state == S_REQ) || (state == S_WAIT) || accept;
  assign o_done       = (state == S_DONE);
  assign o_rdata      = rdata_q;
  assign o_misaligned = misaligned_q;
  assign o_err        = err_q;

  // Request fields are forced to zero outside REQ so an idle bus reads all-zero.
  assign o_dmem_req   = (state == S_REQ);
  assign o_dmem_wen   = o_dmem_req && !op_load;
  assign o_dmem_addr  = o_dmem_req ? {op_addr[31:2], 2'b00} : 32'd0;
  assign o_dmem_mask  = o_dmem_req ? mask : 4'd0;
  assign o_dmem_wdata = o_dmem_wen ? wdata_rep : 32'd0;

endmodule

// File: tb/tb_lsu_seq.sv
// tb/tb_lsu_seq.sv - self-checking bench for lsu_seq
module tb_lsu_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_is_load = 1'b0;
  logic        i_is_store = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_wdata = 32'd0;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_misaligned;
  logic        o_err;
  logic        o_dmem_req;
  logic        o_dmem_wen;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_mask;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_ready = 1'b0;
  logic        i_dmem_rvalid = 1'b0;
  logic [31:0] i_dmem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  lsu_seq #(.WAIT_LIMIT(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_valid(i_valid), .i_is_load(i_is_load), .i_is_store(i_is_store),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata),
    .o_misaligned(o_misaligned), .o_err(o_err),
    .o_dmem_req(o_dmem_req), .o_dmem_wen(o_dmem_wen), .o_dmem_addr(o_dmem_addr),
    .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_ready(i_dmem_ready), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdy_dly;
    int          rv_dly;
    logic [31:0] mem_rdata;
    logic        exp_req;
    logic [3:0]  exp_mask;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ld, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int rdy, input int rv, input logic [31:0] mrd,
                              input logic ereq, input logic [3:0] emask,
                              input logic [31:0] eaddr, input logic [31:0] ewd,
                              input logic [31:0] erd, input logic emis, input logic eerr);
    vec_t v;
    v.ld = ld; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdy_dly = rdy; v.rv_dly = rv; v.mem_rdata = mrd;
    v.exp_req = ereq; v.exp_mask = emask; v.exp_addr = eaddr; v.exp_wdata = ewd;
    v.exp_rdata = erd; v.exp_mis = emis; v.exp_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_op(input logic ld, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
    i_valid = 1'b1; i_is_load = ld; i_is_store = !ld;
    i_funct3 = f3; i_addr = addr; i_wdata = wdata;
  endtask

  task automatic clear_op();
    i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
    i_funct3 = 3'd0; i_addr = 32'd0; i_wdata = 32'd0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int          cyc;
    int          req_n;
    int          wait_n;
    logic        granted;
    logic        seen_req;
    logic [3:0]  m;
    logic [31:0] a;
    logic [31:0] wd;
    logic        wen;
    start_op(v.ld, v.f3, v.addr, v.wdata);
    #1;
    chk($sformatf("v%0d stall_accept", id), 32'(o_stall), 32'd1);
    step();
    clear_op();
    cyc = 0; req_n = 0; wait_n = 0; granted = 1'b0; seen_req = 1'b0;
    m = 4'd0; a = 32'd0; wd = 32'd0; wen = 1'b0;
    while (!o_done && cyc < 40) begin
      i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0;
      if (o_dmem_req) begin
        if (!seen_req) begin
          m = o_dmem_mask; a = o_dmem_addr; wd = o_dmem_wdata; wen = o_dmem_wen;
        end
        seen_req = 1'b1;
        if (req_n == v.rdy_dly) begin
          i_dmem_ready = 1'b1;
          granted = 1'b1;
        end
        req_n++;
      end else if (granted) begin
        if (wait_n == v.rv_dly) begin
          i_dmem_rvalid = 1'b1;
          i_dmem_rdata = v.mem_rdata;
        end
        wait_n++;
      end
      step();
      cyc++;
    end
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0;
    chk($sformatf("v%0d done", id), 32'(o_done), 32'd1);
    chk($sformatf("v%0d stall_done", id), 32'(o_stall), 32'd0);
    chk($sformatf("v%0d rdata", id), o_rdata, v.exp_rdata);
    chk($sformatf("v%0d misaligned", id), 32'(o_misaligned), 32'(v.exp_mis));
    chk($sformatf("v%0d err", id), 32'(o_err), 32'(v.exp_err));
    chk($sformatf("v%0d req_seen", id), 32'(seen_req), 32'(v.exp_req));
    if (v.exp_req) begin
      chk($sformatf("v%0d mask", id), 32'(m), 32'(v.exp_mask));
      chk($sformatf("v%0d addr", id), a, v.exp_addr);
      chk($sformatf("v%0d wen", id), 32'(wen), 32'(!v.ld));
      if (!v.ld) chk($sformatf("v%0d wdata", id), wd, v.exp_wdata);
    end
    step();
    chk($sformatf("v%0d done_drop", id), 32'(o_done), 32'd0);
    chk($sformatf("v%0d rdata_hold", id), o_rdata, v.exp_rdata);
  endtask

  initial begin
    // ld, f3, addr, wdata, rdy, rv, mem_rdata, req, mask, addr, wdata, rdata, mis, err
    vecs.push_back(mk(1, 3'b000, 32'h103, 0, 0, 0, 32'h80FF1234, 1, 4'b1000, 32'h100, 0, 32'hFFFFFF80, 0, 0));
    vecs.push_back(mk(1, 3'b101, 32'h202, 0, 0, 1, 32'hBEEF0000, 1, 4'b1100, 32'h200, 0, 32'h0000BEEF, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h202, 0, 1, 0, 32'hBEEF0000, 1, 4'b1100, 32'h200, 0, 32'hFFFFBEEF, 0, 0));
    vecs.push_back(mk(1, 3'b100, 32'h102, 0, 0, 0, 32'h80FF1234, 1, 4'b0100, 32'h100, 0, 32'h000000FF, 0, 0));
    vecs.push_back(mk(1, 3'b000, 32'h102, 0, 0, 0, 32'h80FF1234, 1, 4'b0100, 32'h100, 0, 32'hFFFFFFFF, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h200, 0, 0, 0, 32'h12348001, 1, 4'b0011, 32'h200, 0, 32'hFFFF8001, 0, 0));
    vecs.push_back(mk(1, 3'b010, 32'h300, 0, 0, 0, 32'hDEADBEEF, 1, 4'b1111, 32'h300, 0, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, 3'b000, 32'h41, 32'h123456AB, 0, 0, 0, 1, 4'b0010, 32'h40, 32'hABABABAB, 0, 0, 0));
    vecs.push_back(mk(0, 3'b001, 32'h42, 32'hAAAA5678, 0, 0, 0, 1, 4'b1100, 32'h40, 32'h56785678, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h10, 32'hCAFEF00D, 0, 0, 0, 1, 4'b1111, 32'h10, 32'hCAFEF00D, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 32'h06, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 3'b001, 32'h03, 32'h1111, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 3'b001, 32'h201, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 3'b000, 32'h003, 0, 0, 0, 32'h7F000000, 1, 4'b1000, 32'h0, 0, 32'h0000007F, 0, 0));
    vecs.push_back(mk(0, 3'b000, 32'h07, 32'h5A, 3, 0, 0, 1, 4'b1000, 32'h4, 32'h5A5A5A5A, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 32'h08, 0, 3, 0, 32'h01234567, 1, 4'b1111, 32'h8, 0, 32'h01234567, 0, 0));
    vecs.push_back(mk(1, 3'b010, 32'h08, 0, 3, 1, 32'h01234567, 1, 4'b1111, 32'h8, 0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 3'b010, 32'h0C, 0, 99, 0, 32'h55555555, 1, 4'b1111, 32'hC, 0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 3'b010, 32'h14, 0, 0, 2, 32'h0BADF00D, 1, 4'b1111, 32'h14, 0, 32'h0BADF00D, 0, 0));
    vecs.push_back(mk(1, 3'b010, 32'h14, 0, 1, 2, 32'h0BADF00D, 1, 4'b1111, 32'h14, 0, 32'h0, 0, 1));
    vecs.push_back(mk(1, 3'b011, 32'h18, 0, 0, 0, 32'h89ABCDEF, 1, 4'b1111, 32'h18, 0, 32'h89ABCDEF, 0, 0));
    vecs.push_back(mk(0, 3'b100, 32'h20, 32'h000000AB, 0, 0, 0, 1, 4'b1111, 32'h20, 32'h000000AB, 0, 0, 0));
    vecs.push_back(mk(0, 3'b100, 32'h21, 32'h000000AB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Reset state
    step();
    step();
    chk("rst stall", 32'(o_stall), 32'd0);
    chk("rst done", 32'(o_done), 32'd0);
    chk("rst req", 32'(o_dmem_req), 32'd0);
    chk("rst mask", 32'(o_dmem_mask), 32'd0);
    chk("rst rdata", o_rdata, 32'd0);
    chk("rst err_mis", {30'd0, o_err, o_misaligned}, 32'd0);
    i_rst_n = 1'b1;
    step();

    // LB latency: ready and rvalid one cycle apart, done three cycles after accept
    start_op(1'b1, 3'b000, 32'h103, 32'd0);
    step();
    clear_op();
    chk("lat req_c1", 32'(o_dmem_req), 32'd1);
    chk("lat done_c1", 32'(o_done), 32'd0);
    i_dmem_ready = 1'b1;
    step();
    i_dmem_ready = 1'b0;
    chk("lat done_c2", 32'(o_done), 32'd0);
    chk("lat stall_c2", 32'(o_stall), 32'd1);
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h80FF1234;
    step();
    i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0;
    chk("lat done_c3", 32'(o_done), 32'd1);
    chk("lat rdata", o_rdata, 32'hFFFFFF80);
    step();

    // SB with ready held low for three cycles: request stable throughout
    start_op(1'b0, 3'b000, 32'h41, 32'h123456AB);
    step();
    clear_op();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sb_hold%0d req", k), 32'(o_dmem_req), 32'd1);
      chk($sformatf("sb_hold%0d addr", k), o_dmem_addr, 32'h40);
      chk($sformatf("sb_hold%0d mask", k), 32'(o_dmem_mask), 32'b0010);
      chk($sformatf("sb_hold%0d wdata", k), o_dmem_wdata, 32'hABABABAB);
      chk($sformatf("sb_hold%0d stall", k), 32'(o_stall), 32'd1);
      if (k == 3) i_dmem_ready = 1'b1;
      step();
    end
    i_dmem_ready = 1'b0;
    chk("sb done", 32'(o_done), 32'd1);
    chk("sb stall_done", 32'(o_stall), 32'd0);
    chk("sb req_drop", 32'(o_dmem_req), 32'd0);
    step();

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Load with ready and rvalid together in REQ: that rvalid is not captured
    start_op(1'b1, 3'b010, 32'h20, 32'd0);
    step();
    clear_op();
    i_dmem_ready = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h11111111;
    step();
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h22222222;
    chk("both done_early", 32'(o_done), 32'd0);
    step();
    i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0;
    chk("both done", 32'(o_done), 32'd1);
    chk("both rdata", o_rdata, 32'h22222222);
    step();
    // Stray rvalid while idle is ignored
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h33333333;
    step();
    i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0;
    chk("idle_rvalid rdata", o_rdata, 32'h22222222);
    chk("idle_rvalid done", 32'(o_done), 32'd0);

    // Reset asserted while waiting for read data
    start_op(1'b1, 3'b010, 32'h30, 32'd0);
    step();
    clear_op();
    i_dmem_ready = 1'b1;
    step();
    i_dmem_ready = 1'b0;
    chk("mid_rst stall_before", 32'(o_stall), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst stall", 32'(o_stall), 32'd0);
    chk("mid_rst done", 32'(o_done), 32'd0);
    chk("mid_rst req", 32'(o_dmem_req), 32'd0);
    chk("mid_rst addr", o_dmem_addr, 32'd0);
    chk("mid_rst rdata", o_rdata, 32'd0);
    chk("mid_rst err_mis", {30'd0, o_err, o_misaligned}, 32'd0);
    step();
    i_rst_n = 1'b1;
    step();
    run_vec(100, mk(0, 3'b010, 32'h10, 32'h0F0E0D0C, 0, 0, 0, 1, 4'b1111, 32'h10, 32'h0F0E0D0C, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
